op2: RTL and testbench



---
 rtl/op2.sv | 96 +++++++++
 tb/tb_op2.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/op2.sv
// Second-stage accumulator/activation unit: removes the inversion offset from each
// first-stage sum, accumulates NCHUNK beats, adds bias, ReLU/shift/saturate to 4 bits.
module op2 #(
  parameter int NCHUNK = 4,
  parameter int ACC_W  = 16,
  parameter int BIAS_W = 12,
  parameter int SHIFT  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8:0]               psum_in,
  input  logic [5:0]               ninv_in,
  input  logic signed [BIAS_W-1:0] bias_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               data_out,
  output logic                     sat_out
);

  localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_r;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] bias_base;
  logic signed [10:0]      term;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] q;
  logic                    beat_fire;
  logic                    first;
  logic                    last;
  logic [3:0]              act;
  logic                    act_sat;

  assign in_ready  = !out_valid || out_ready;
  assign beat_fire = in_valid && in_ready;
  assign first     = (cnt == '0);
  assign last      = (cnt == LAST);
  assign bias_ext  = ACC_W'(bias_in);

  // ~d = 15 - d, so each inverted input contributes an extra 15 that must be removed.
  assign term = $signed({2'b00, psum_in}) - $signed(11'(ninv_in) * 11'd15);

  // The first beat of a group starts from zero and the live bias, so a single-beat
  // group (NCHUNK=1) can be both first and last without an intermediate register.
  always_comb begin
    acc_base  = first ? '0 : acc;
    bias_base = first ? bias_ext : bias_r;
    sum       = SUM_W'(acc_base) + SUM_W'(term) + SUM_W'(bias_base);
    q         = sum >>> SHIFT;
    act       = '0;
    act_sat   = 1'b0;
    if (!sum[SUM_W-1] && (sum != '0)) begin
      if (q > SUM_W'(15)) begin
        act     = '1;
        act_sat = 1'b1;
      end else begin
        act = q[3:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_out   <= 1'b0;
      acc       <= '0;
      bias_r    <= '0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (beat_fire) begin
        if (first)
          bias_r <= bias_ext;
        if (last) begin
          cnt       <= '0;
          out_valid <= 1'b1;
          data_out  <= act;
          sat_out   <= act_sat;
        end else begin
          cnt <= cnt + CNT_W'(1);
          acc <= acc_base + ACC_W'(term);
        end
      end
    end
  end

endmodule

// File: tb/tb_op2.sv
// Directed self-checking bench for op2: default NCHUNK=4 instance plus an NCHUNK=1
// instance sharing the same upstream stimulus.
module tb_op2;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [8:0]        psum_in;
  logic [5:0]        ninv_in;
  logic signed [11:0] bias_in;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        data_out;
  logic              sat_out;
  logic              in_ready1;
  logic              out_valid1;
  logic [3:0]        data_out1;
  logic              sat_out1;

  int n_checks = 0;
  int n_fail   = 0;

  op2 dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .psum_in(psum_in), .ninv_in(ninv_in), .bias_in(bias_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .sat_out(sat_out)
  );

  op2 #(.NCHUNK(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .psum_in(psum_in), .ninv_in(ninv_in), .bias_in(bias_in),
    .out_valid(out_valid1), .out_ready(1'b1), .data_out(data_out1), .sat_out(sat_out1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One beat; waits (bounded) for in_ready, then transfers on the next edge.
  task automatic send(input int p, input int n, input int b);
    int w;
    w = 0;
    psum_in  = 9'(p);
    ninv_in  = 6'(n);
    bias_in  = 12'(b);
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clock); #1;
      w++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Four beats; bias b on the first beat, bx on the others (must be ignored by NCHUNK=4).
  task automatic group(input int p, input int n, input int b, input int bx);
    send(p, n, b);
    for (int unsigned i = 1; i < 4; i++) send(p, n, bx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int bp[3] = '{20, 50, 64};
  int bn[3] = '{0, 1, 0};
  int bb[3] = '{0, 0, 17};
  int bd[3] = '{5, 8, 15};
  int bs[3] = '{0, 0, 1};

  initial begin
    reset = 1'b1; in_valid = 1'b0; psum_in = '0; ninv_in = '0; bias_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_sat", 32'(sat_out), 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_in_ready1", 32'(in_ready1), 1);

    // 4 x 40 = 160 -> 10
    group(40, 0, 0, 0);
    check("g40_valid", 32'(out_valid), 1);
    check("g40_data", 32'(data_out), 10);
    check("g40_sat", 32'(sat_out), 0);
    check("n1_g40_valid", 32'(out_valid1), 1);
    check("n1_g40_data", 32'(data_out1), 2);
    @(posedge clock); #1;
    check("g40_drain", 32'(out_valid), 0);

    // 400 >> 4 = 25 -> saturate
    group(100, 0, 0, 777);
    check("g100_data", 32'(data_out), 15);
    check("g100_sat", 32'(sat_out), 1);
    check("n1_g100_data", 32'(data_out1), 15);
    check("n1_g100_sat", 32'(sat_out1), 1);

    // terms 0, bias -5 -> ReLU to 0; later-beat bias 900 must be ignored
    group(30, 2, -5, 900);
    check("relu_valid", 32'(out_valid), 1);
    check("relu_data", 32'(data_out), 0);
    check("relu_sat", 32'(sat_out), 0);
    check("n1_relu_data", 32'(data_out1), 15);

    // 480 - 15*32 = 0, bias 100 -> 6
    group(480, 32, 100, -2000);
    check("bias_data", 32'(data_out), 6);
    check("bias_sat", 32'(sat_out), 0);
    check("n1_neg_data", 32'(data_out1), 0);
    check("n1_neg_sat", 32'(sat_out1), 0);
    @(posedge clock); #1;

    // Backpressure: 4 x 16 = 64 -> 4 held while next group's first beat stalls
    out_ready = 1'b0;
    group(16, 0, 0, 0);
    check("bp_valid", 32'(out_valid), 1);
    check("bp_data", 32'(data_out), 4);
    check("bp_in_ready", 32'(in_ready), 0);
    psum_in = 9'd48; ninv_in = '0; bias_in = '0; in_valid = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_data", 32'(data_out), 4);
      check("bp_hold_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("bp_out_xfer", 32'(out_valid), 0);
    for (int unsigned i = 0; i < 3; i++) send(48, 0, 0);
    check("bp_next_valid", 32'(out_valid), 1);
    check("bp_next_data", 32'(data_out), 12);
    @(posedge clock); #1;

    // Back-to-back: three groups, output on cycles 5, 9, 13
    for (int unsigned k = 0; k < 12; k++) begin
      psum_in  = 9'(bp[k/4]);
      ninv_in  = 6'(bn[k/4]);
      bias_in  = (k % 4 == 0) ? 12'(bb[k/4]) : 12'sd555;
      in_valid = 1'b1;
      #1;
      check("b2b_in_ready", 32'(in_ready), 1);
      @(posedge clock); #1;
      check("b2b_valid", 32'(out_valid), (k % 4 == 3) ? 32'd1 : 32'd0);
      if (k % 4 == 3) begin
        check("b2b_data", 32'(data_out), 32'(bd[k/4]));
        check("b2b_sat", 32'(sat_out), 32'(bs[k/4]));
      end
    end
    in_valid = 1'b0;
    @(posedge clock); #1;

    // Asynchronous reset after two beats of a group
    send(200, 0, 0);
    send(200, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_data", 32'(data_out), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    @(posedge clock); #1;
    reset = 1'b0;
    group(16, 0, 0, 0);
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_data", 32'(data_out), 4);

    // Reset while an output is pending
    out_ready = 1'b0;
    @(posedge clock); #1;
    check("pend_hold", 32'(out_valid), 1);
    #3 reset = 1'b1;
    #1;
    check("pend_rst_valid", 32'(out_valid), 0);
    check("pend_rst_data", 32'(data_out), 0);
    check("pend_rst_sat", 32'(sat_out), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
